// File: rtl/cxl_d2h_req_tracker.sv
// CXL.cache device-to-host request tracker.
// Allocates a CQID per cache request, issues it on the D2H request channel
// through one registered stage, and retires entries from H2D GO / WritePull
// responses.

// One tracker entry: lifecycle of a single CQID from allocation to retirement.
module cxl_d2h_req_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_alloc,
  input  logic       i_alloc_wr,
  input  logic       i_rsp,
  input  logic [3:0] i_rsp_opcode,
  input  logic [3:0] i_rsp_data,
  output logic       o_free,
  output logic       o_legal,
  output logic       o_done,
  output logic       o_wrpull,
  output logic       o_err_done,
  output logic [3:0] o_state
);
  localparam logic [3:0] OP_WRITE_PULL      = 4'b0001;
  localparam logic [3:0] OP_GO              = 4'b0100;
  localparam logic [3:0] OP_GO_WRITE_PULL   = 4'b0101;
  localparam logic [3:0] OP_EXT_CMP         = 4'b0110;
  localparam logic [3:0] OP_GO_WP_DROP      = 4'b1000;
  localparam logic [3:0] OP_FAST_GO         = 4'b1100;
  localparam logic [3:0] OP_FAST_GO_WP      = 4'b1101;
  localparam logic [3:0] OP_GO_ERR_WP       = 4'b1111;

  typedef enum logic [2:0] {
    S_FREE, S_WAIT_GO, S_WAIT_BOTH, S_WAIT_PULL, S_WAIT_GO_W
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_rsp_next;
  logic [3:0] r_go_state;

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FREE;
    else        r_state <= w_next;
  end

  // Remember the GO cache state when the GO arrives ahead of its WritePull.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_go_state <= '0;
    else if (i_rsp && r_state == S_WAIT_BOTH && i_rsp_opcode == OP_GO)
      r_go_state <= i_rsp_data;
  end

  // Response decode for the current state, then next-state selection.
  always_comb begin
    o_legal    = 1'b0;
    o_done     = 1'b0;
    o_wrpull   = 1'b0;
    o_err_done = 1'b0;
    o_state    = i_rsp_data;
    w_rsp_next = r_state;
    case (r_state)
      S_WAIT_GO, S_WAIT_GO_W: begin
        if (i_rsp_opcode == OP_GO || i_rsp_opcode == OP_FAST_GO) begin
          o_legal = 1'b1; o_done = 1'b1; w_rsp_next = S_FREE;
        end else if (i_rsp_opcode == OP_EXT_CMP) begin
          o_legal = 1'b1;
        end
      end
      S_WAIT_BOTH: begin
        case (i_rsp_opcode)
          OP_WRITE_PULL: begin
            o_legal = 1'b1; o_wrpull = 1'b1; w_rsp_next = S_WAIT_GO_W;
          end
          OP_GO: begin
            o_legal = 1'b1; w_rsp_next = S_WAIT_PULL;
          end
          OP_GO_WRITE_PULL, OP_FAST_GO_WP: begin
            o_legal = 1'b1; o_wrpull = 1'b1; o_done = 1'b1; w_rsp_next = S_FREE;
          end
          OP_GO_WP_DROP: begin
            o_legal = 1'b1; o_done = 1'b1; w_rsp_next = S_FREE;
          end
          OP_GO_ERR_WP: begin
            o_legal = 1'b1; o_wrpull = 1'b1; o_done = 1'b1; o_err_done = 1'b1;
            w_rsp_next = S_FREE;
          end
          OP_EXT_CMP: o_legal = 1'b1;
          default: ;
        endcase
      end
      S_WAIT_PULL: begin
        if (i_rsp_opcode == OP_WRITE_PULL) begin
          o_legal = 1'b1; o_wrpull = 1'b1; o_done = 1'b1;
          o_state = r_go_state; w_rsp_next = S_FREE;
        end else if (i_rsp_opcode == OP_EXT_CMP) begin
          o_legal = 1'b1;
        end
      end
      default: ;
    endcase
    // Allocation only ever hits a FREE entry, and a response to a FREE entry
    // is never legal, so the two cannot collide.
    w_next = r_state;
    if (i_alloc)              w_next = i_alloc_wr ? S_WAIT_BOTH : S_WAIT_GO;
    else if (i_rsp && o_legal) w_next = w_rsp_next;
  end

  assign o_free = (r_state == S_FREE);
endmodule

module cxl_d2h_req_tracker #(
  parameter int NUM_CQID = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_opcode_i,
  input  logic [45:0] req_addr_i,
  input  logic        req_nt_i,
  output logic        d2h_req_valid_o,
  input  logic        d2h_req_ready_i,
  output logic [4:0]  d2h_req_opcode_o,
  output logic [45:0] d2h_req_addr_o,
  output logic [11:0] d2h_req_cqid_o,
  output logic        d2h_req_nt_o,
  input  logic        h2d_rsp_valid_i,
  input  logic [3:0]  h2d_rsp_opcode_i,
  input  logic [11:0] h2d_rsp_cqid_i,
  input  logic [11:0] h2d_rsp_data_i,
  output logic        done_valid_o,
  output logic [11:0] done_cqid_o,
  output logic [3:0]  done_state_o,
  output logic        done_err_o,
  output logic        wrpull_valid_o,
  output logic [11:0] wrpull_cqid_o,
  output logic [11:0] wrpull_uqid_o,
  output logic        err_unexp_o,
  output logic [12:0] outstanding_o
);
  localparam int IW = $clog2(NUM_CQID);

  localparam logic [4:0] OP_ITOMWR      = 5'b00110;
  localparam logic [4:0] OP_MEM_WR      = 5'b00111;
  localparam logic [4:0] OP_CLEAN_EVICT = 5'b01001;
  localparam logic [4:0] OP_DIRTY_EVICT = 5'b01010;
  localparam logic [4:0] OP_WOWR_INV    = 5'b01100;
  localparam logic [4:0] OP_WOWR_INVF   = 5'b01101;
  localparam logic [4:0] OP_WR_INV      = 5'b01110;

  function automatic logic is_write(input logic [4:0] op);
    case (op)
      OP_ITOMWR, OP_MEM_WR, OP_CLEAN_EVICT, OP_DIRTY_EVICT,
      OP_WOWR_INV, OP_WOWR_INVF, OP_WR_INV: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  logic [NUM_CQID-1:0]      w_free, w_ent_legal, w_ent_done, w_ent_wrpull, w_ent_err;
  logic [NUM_CQID-1:0][3:0] w_ent_state;
  logic [IW-1:0]            w_alloc_idx, w_sel;
  logic                     w_any_free, w_accept, w_in_range, w_legal, w_rsp_ok, w_retire;

  logic        r_d2h_valid, r_d2h_nt;
  logic [4:0]  r_d2h_opcode;
  logic [45:0] r_d2h_addr;
  logic [11:0] r_d2h_cqid;
  logic        r_done, r_done_err, r_wrpull, r_err;
  logic [11:0] r_done_cqid, r_wrpull_cqid, r_wrpull_uqid;
  logic [3:0]  r_done_state;
  logic [12:0] r_outstanding;

  // Lowest-index FREE entry, from the pre-update entry states.
  always_comb begin
    w_alloc_idx = '0;
    w_any_free  = 1'b0;
    for (int i = NUM_CQID - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_idx = IW'(i);
        w_any_free  = 1'b1;
      end
    end
  end

  assign req_ready_o = w_any_free && (!r_d2h_valid || d2h_req_ready_i);
  assign w_accept    = req_valid_i && req_ready_o;

  assign w_in_range = ({1'b0, h2d_rsp_cqid_i} < 13'(NUM_CQID));
  assign w_sel      = h2d_rsp_cqid_i[IW-1:0];
  assign w_legal    = w_in_range && w_ent_legal[w_sel];
  assign w_rsp_ok   = h2d_rsp_valid_i && w_legal;
  assign w_retire   = w_rsp_ok && w_ent_done[w_sel];

  for (genvar g = 0; g < NUM_CQID; g++) begin : g_ent
    cxl_d2h_req_entry u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_alloc      (w_accept && (w_alloc_idx == IW'(g))),
      .i_alloc_wr   (is_write(req_opcode_i)),
      .i_rsp        (h2d_rsp_valid_i && w_in_range && (w_sel == IW'(g))),
      .i_rsp_opcode (h2d_rsp_opcode_i),
      .i_rsp_data   (h2d_rsp_data_i[3:0]),
      .o_free       (w_free[g]),
      .o_legal      (w_ent_legal[g]),
      .o_done       (w_ent_done[g]),
      .o_wrpull     (w_ent_wrpull[g]),
      .o_err_done   (w_ent_err[g]),
      .o_state      (w_ent_state[g])
    );
  end

  // D2H request stage: load on accept, hold while the link stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d2h_valid  <= 1'b0;
      r_d2h_opcode <= '0;
      r_d2h_addr   <= '0;
      r_d2h_cqid   <= '0;
      r_d2h_nt     <= 1'b0;
    end else if (w_accept) begin
      r_d2h_valid  <= 1'b1;
      r_d2h_opcode <= req_opcode_i;
      r_d2h_addr   <= req_addr_i;
      r_d2h_cqid   <= 12'(w_alloc_idx);
      r_d2h_nt     <= req_nt_i;
    end else if (d2h_req_ready_i) begin
      r_d2h_valid  <= 1'b0;
    end
  end

  // Registered response pulses; data fields hold their last pulsed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done        <= 1'b0;
      r_done_cqid   <= '0;
      r_done_state  <= '0;
      r_done_err    <= 1'b0;
      r_wrpull      <= 1'b0;
      r_wrpull_cqid <= '0;
      r_wrpull_uqid <= '0;
      r_err         <= 1'b0;
    end else begin
      r_done   <= w_retire;
      r_wrpull <= w_rsp_ok && w_ent_wrpull[w_sel];
      r_err    <= h2d_rsp_valid_i && !w_legal;
      if (w_retire) begin
        r_done_cqid  <= h2d_rsp_cqid_i;
        r_done_state <= w_ent_state[w_sel];
        r_done_err   <= w_ent_err[w_sel];
      end
      if (w_rsp_ok && w_ent_wrpull[w_sel]) begin
        r_wrpull_cqid <= h2d_rsp_cqid_i;
        r_wrpull_uqid <= h2d_rsp_data_i;
      end
    end
  end

  // Occupancy count tracks allocations minus retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_outstanding <= '0;
    else        r_outstanding <= r_outstanding + 13'(w_accept) - 13'(w_retire);
  end

  assign d2h_req_valid_o  = r_d2h_valid;
  assign d2h_req_opcode_o = r_d2h_opcode;
  assign d2h_req_addr_o   = r_d2h_addr;
  assign d2h_req_cqid_o   = r_d2h_cqid;
  assign d2h_req_nt_o     = r_d2h_nt;
  assign done_valid_o     = r_done;
  assign done_cqid_o      = r_done_cqid;
  assign done_state_o     = r_done_state;
  assign done_err_o       = r_done_err;
  assign wrpull_valid_o   = r_wrpull;
  assign wrpull_cqid_o    = r_wrpull_cqid;
  assign wrpull_uqid_o    = r_wrpull_uqid;
  assign err_unexp_o      = r_err;
  assign outstanding_o    = r_outstanding;
endmodule

// File: tb/tb_cxl_d2h_req_tracker.sv
// Testbench for cxl_d2h_req_tracker: directed scenarios plus a randomized run
// against a flag-based reference model of the CQID table.
module tb_cxl_d2h_req_tracker;
  localparam int N = 16;

  localparam logic [4:0] RD_CURR = 5'b00001, RD_OWN = 5'b00010, RD_SHARED = 5'b00011;
  localparam logic [4:0] ITOMWR = 5'b00110, DIRTY_EVICT = 5'b01010;
  localparam logic [3:0] WP = 4'b0001, GO = 4'b0100, GO_WP = 4'b0101, EXT = 4'b0110;
  localparam logic [3:0] GO_WP_DROP = 4'b1000, FGO = 4'b1100, FGO_WP = 4'b1101, GO_ERR = 4'b1111;

  logic        clk = 0, rst_n = 0;
  logic        req_valid_i = 0, req_ready_o, req_nt_i = 0;
  logic [4:0]  req_opcode_i = 0;
  logic [45:0] req_addr_i = 0;
  logic        d2h_req_valid_o, d2h_req_ready_i = 1, d2h_req_nt_o;
  logic [4:0]  d2h_req_opcode_o;
  logic [45:0] d2h_req_addr_o;
  logic [11:0] d2h_req_cqid_o;
  logic        h2d_rsp_valid_i = 0;
  logic [3:0]  h2d_rsp_opcode_i = 0;
  logic [11:0] h2d_rsp_cqid_i = 0, h2d_rsp_data_i = 0;
  logic        done_valid_o, done_err_o, wrpull_valid_o, err_unexp_o;
  logic [11:0] done_cqid_o, wrpull_cqid_o, wrpull_uqid_o;
  logic [3:0]  done_state_o;
  logic [12:0] outstanding_o;

  int n_checks = 0, n_fail = 0;

  cxl_d2h_req_tracker #(.NUM_CQID(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
    .req_addr_i(req_addr_i), .req_nt_i(req_nt_i),
    .d2h_req_valid_o(d2h_req_valid_o), .d2h_req_ready_i(d2h_req_ready_i),
    .d2h_req_opcode_o(d2h_req_opcode_o), .d2h_req_addr_o(d2h_req_addr_o),
    .d2h_req_cqid_o(d2h_req_cqid_o), .d2h_req_nt_o(d2h_req_nt_o),
    .h2d_rsp_valid_i(h2d_rsp_valid_i), .h2d_rsp_opcode_i(h2d_rsp_opcode_i),
    .h2d_rsp_cqid_i(h2d_rsp_cqid_i), .h2d_rsp_data_i(h2d_rsp_data_i),
    .done_valid_o(done_valid_o), .done_cqid_o(done_cqid_o), .done_state_o(done_state_o),
    .done_err_o(done_err_o), .wrpull_valid_o(wrpull_valid_o), .wrpull_cqid_o(wrpull_cqid_o),
    .wrpull_uqid_o(wrpull_uqid_o), .err_unexp_o(err_unexp_o), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  // ---- reference model: per-CQID flags ----
  bit       m_busy [N];
  bit       m_wr   [N];
  bit       m_go   [N];
  bit       m_pull [N];
  bit [3:0] m_gst  [N];

  function automatic bit model_is_wr(input logic [4:0] op);
    return op inside {5'd6, 5'd7, 5'd9, 5'd10, 5'd12, 5'd13, 5'd14};
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i];
    return c;
  endfunction

  // Applies one response to the model and reports the pulses it should cause.
  task automatic model_rsp(input logic [3:0] op, input int cq, input logic [11:0] data,
                           output bit err, output bit done, output bit pull,
                           output bit derr, output logic [3:0] dst);
    bit both_open, is_go;
    err = 1; done = 0; pull = 0; derr = 0; dst = data[3:0];
    if (cq >= N || !m_busy[cq]) return;
    is_go = (op == GO || op == FGO);
    both_open = m_wr[cq] && !m_go[cq] && !m_pull[cq];
    if (op == EXT) err = 0;
    else if (!m_wr[cq]) begin
      if (is_go) begin err = 0; done = 1; end
    end else if (op == WP && !m_pull[cq]) begin
      err = 0; pull = 1; m_pull[cq] = 1;
      if (m_go[cq]) begin done = 1; dst = m_gst[cq]; end
    end else if (is_go && !m_go[cq] && (op == GO || m_pull[cq])) begin
      err = 0; m_go[cq] = 1; m_gst[cq] = data[3:0];
      if (m_pull[cq]) done = 1;
    end else if (both_open && (op == GO_WP || op == FGO_WP)) begin
      err = 0; pull = 1; done = 1;
    end else if (both_open && op == GO_WP_DROP) begin
      err = 0; done = 1;
    end else if (both_open && op == GO_ERR) begin
      err = 0; pull = 1; done = 1; derr = 1;
    end
    if (done) m_busy[cq] = 0;
  endtask

  // ---- stimulus helpers (no checking) ----
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_req(input logic [4:0] op, input logic [45:0] a, input logic nt);
    req_valid_i = 1; req_opcode_i = op; req_addr_i = a; req_nt_i = nt;
    tick();
    req_valid_i = 0;
  endtask

  task automatic send_rsp(input logic [3:0] op, input logic [11:0] cq, input logic [11:0] d);
    h2d_rsp_valid_i = 1; h2d_rsp_opcode_i = op; h2d_rsp_cqid_i = cq; h2d_rsp_data_i = d;
    tick();
    h2d_rsp_valid_i = 0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    n_checks++; if (d2h_req_valid_o !== 0 || done_valid_o !== 0 || wrpull_valid_o !== 0 || err_unexp_o !== 0) begin
      n_fail++; $display("FAIL reset_pulses: d2h=%b done=%b wrpull=%b err=%b expected all 0",
                         d2h_req_valid_o, done_valid_o, wrpull_valid_o, err_unexp_o); end
    rst_n = 1;
    tick();
    n_checks++; if (req_ready_o !== 1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
    n_checks++; if (d2h_req_valid_o !== 0) begin n_fail++; $display("FAIL reset_d2h_valid: got %b exp 0", d2h_req_valid_o); end
    n_checks++; if (outstanding_o !== 0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding_o); end
    n_checks++; if (d2h_req_cqid_o !== 0 || done_cqid_o !== 0 || wrpull_uqid_o !== 0) begin
      n_fail++; $display("FAIL reset_data: cqid=%h done_cqid=%h uqid=%h exp 0", d2h_req_cqid_o, done_cqid_o, wrpull_uqid_o); end
  endtask

  task automatic test_read();
    send_req(RD_OWN, 46'h1234, 0);
    n_checks++; if (d2h_req_valid_o !== 1 || d2h_req_cqid_o !== 0 || d2h_req_opcode_o !== 5'b00010 || d2h_req_addr_o !== 46'h1234) begin
      n_fail++; $display("FAIL read_issue: v=%b cqid=%h op=%b addr=%h exp 1/0/00010/1234",
                         d2h_req_valid_o, d2h_req_cqid_o, d2h_req_opcode_o, d2h_req_addr_o); end
    n_checks++; if (outstanding_o !== 1) begin n_fail++; $display("FAIL read_outstanding: got %0d exp 1", outstanding_o); end
    send_rsp(GO, 0, 12'h003);
    n_checks++; if (done_valid_o !== 1 || done_cqid_o !== 0 || done_state_o !== 3 || done_err_o !== 0) begin
      n_fail++; $display("FAIL read_done: v=%b cqid=%h st=%h err=%b exp 1/0/3/0", done_valid_o, done_cqid_o, done_state_o, done_err_o); end
    n_checks++; if (outstanding_o !== 0 || d2h_req_valid_o !== 0) begin
      n_fail++; $display("FAIL read_retire: outstanding=%0d d2h_v=%b exp 0/0", outstanding_o, d2h_req_valid_o); end
    tick();
    n_checks++; if (done_valid_o !== 0) begin n_fail++; $display("FAIL read_done_pulse: got %b exp 0", done_valid_o); end
  endtask

  task automatic test_write_combined();
    send_req(DIRTY_EVICT, 46'h40, 0);
    n_checks++; if (d2h_req_cqid_o !== 0 || d2h_req_opcode_o !== DIRTY_EVICT) begin
      n_fail++; $display("FAIL wc_issue: cqid=%h op=%h exp 0/%h", d2h_req_cqid_o, d2h_req_opcode_o, DIRTY_EVICT); end
    send_rsp(GO_WP, 0, 12'h0AB);
    n_checks++; if (wrpull_valid_o !== 1 || wrpull_uqid_o !== 12'h0AB || wrpull_cqid_o !== 0) begin
      n_fail++; $display("FAIL wc_wrpull: v=%b uqid=%h cqid=%h exp 1/0ab/0", wrpull_valid_o, wrpull_uqid_o, wrpull_cqid_o); end
    n_checks++; if (done_valid_o !== 1 || done_cqid_o !== 0 || done_err_o !== 0) begin
      n_fail++; $display("FAIL wc_done: v=%b cqid=%h err=%b exp 1/0/0", done_valid_o, done_cqid_o, done_err_o); end
    n_checks++; if (outstanding_o !== 0) begin n_fail++; $display("FAIL wc_outstanding: got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_write_split();
    // WritePull first, GO second
    send_req(ITOMWR, 46'h80, 1);
    send_rsp(WP, 0, 12'h055);
    n_checks++; if (wrpull_valid_o !== 1 || wrpull_uqid_o !== 12'h055 || done_valid_o !== 0) begin
      n_fail++; $display("FAIL split1_pull: wrpull=%b uqid=%h done=%b exp 1/055/0", wrpull_valid_o, wrpull_uqid_o, done_valid_o); end
    send_rsp(GO, 0, 12'h002);
    n_checks++; if (done_valid_o !== 1 || done_state_o !== 2 || wrpull_valid_o !== 0) begin
      n_fail++; $display("FAIL split1_go: done=%b st=%h wrpull=%b exp 1/2/0", done_valid_o, done_state_o, wrpull_valid_o); end
    // GO first, WritePull second
    send_req(ITOMWR, 46'h80, 1);
    send_rsp(GO, 0, 12'h007);
    n_checks++; if (done_valid_o !== 0 || wrpull_valid_o !== 0 || err_unexp_o !== 0 || outstanding_o !== 1) begin
      n_fail++; $display("FAIL split2_go: done=%b wrpull=%b err=%b outst=%0d exp 0/0/0/1",
                         done_valid_o, wrpull_valid_o, err_unexp_o, outstanding_o); end
    send_rsp(WP, 0, 12'h033);
    n_checks++; if (done_valid_o !== 1 || wrpull_valid_o !== 1 || wrpull_uqid_o !== 12'h033 || done_state_o !== 7) begin
      n_fail++; $display("FAIL split2_pull: done=%b wrpull=%b uqid=%h st=%h exp 1/1/033/7",
                         done_valid_o, wrpull_valid_o, wrpull_uqid_o, done_state_o); end
    n_checks++; if (outstanding_o !== 0) begin n_fail++; $display("FAIL split_outstanding: got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < N; i++) begin
      send_req(RD_CURR, 46'(i), 0);
      n_checks++; if (d2h_req_cqid_o !== 12'(i)) begin
        n_fail++; $display("FAIL full_cqid%0d: got %h exp %h", i, d2h_req_cqid_o, 12'(i)); end
    end
    req_valid_i = 1; #1;
    n_checks++; if (req_ready_o !== 0 || outstanding_o !== 13'(N)) begin
      n_fail++; $display("FAIL full_ready: ready=%b outst=%0d exp 0/%0d", req_ready_o, outstanding_o, N); end
    req_valid_i = 0;
    send_rsp(GO, 5, 12'h001);
    n_checks++; if (done_valid_o !== 1 || done_cqid_o !== 5) begin
      n_fail++; $display("FAIL full_go5: done=%b cqid=%h exp 1/5", done_valid_o, done_cqid_o); end
    send_req(RD_SHARED, 46'h555, 0);
    n_checks++; if (d2h_req_valid_o !== 1 || d2h_req_cqid_o !== 5) begin
      n_fail++; $display("FAIL full_realloc: v=%b cqid=%h exp 1/5", d2h_req_valid_o, d2h_req_cqid_o); end
    for (int i = 0; i < N; i++) send_rsp(FGO, 12'(i), 12'h0);
    n_checks++; if (outstanding_o !== 0) begin n_fail++; $display("FAIL full_drain: got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_backpressure();
    d2h_req_ready_i = 0;
    send_req(RD_SHARED, 46'hABCDE, 1);
    for (int c = 0; c < 5; c++) begin
      req_valid_i = 1; req_opcode_i = RD_OWN; req_addr_i = 46'(c); req_nt_i = 0; #1;
      n_checks++; if (req_ready_o !== 0) begin n_fail++; $display("FAIL bp_ready%0d: got %b exp 0", c, req_ready_o); end
      tick();
      n_checks++; if (d2h_req_valid_o !== 1 || d2h_req_cqid_o !== 0 || d2h_req_addr_o !== 46'hABCDE ||
                      d2h_req_opcode_o !== RD_SHARED || d2h_req_nt_o !== 1) begin
        n_fail++; $display("FAIL bp_hold%0d: v=%b cqid=%h addr=%h op=%h nt=%b exp 1/0/abcde/3/1", c,
                           d2h_req_valid_o, d2h_req_cqid_o, d2h_req_addr_o, d2h_req_opcode_o, d2h_req_nt_o); end
    end
    req_valid_i = 0; d2h_req_ready_i = 1;
    tick();
    n_checks++; if (d2h_req_valid_o !== 0 || outstanding_o !== 1) begin
      n_fail++; $display("FAIL bp_release: v=%b outst=%0d exp 0/1", d2h_req_valid_o, outstanding_o); end
    send_rsp(GO, 0, 12'h0);
  endtask

  task automatic test_unexpected();
    send_rsp(GO, 7, 12'h001);
    n_checks++; if (err_unexp_o !== 1 || done_valid_o !== 0 || outstanding_o !== 0) begin
      n_fail++; $display("FAIL unexp_free: err=%b done=%b outst=%0d exp 1/0/0", err_unexp_o, done_valid_o, outstanding_o); end
    tick();
    n_checks++; if (err_unexp_o !== 0) begin n_fail++; $display("FAIL unexp_pulse: got %b exp 0", err_unexp_o); end
    send_req(RD_CURR, 46'h9, 0);
    send_rsp(WP, 0, 12'h011);
    n_checks++; if (err_unexp_o !== 1 || wrpull_valid_o !== 0 || done_valid_o !== 0) begin
      n_fail++; $display("FAIL unexp_wp_read: err=%b wrpull=%b done=%b exp 1/0/0", err_unexp_o, wrpull_valid_o, done_valid_o); end
    send_rsp(GO, 12'h010, 12'h0);
    n_checks++; if (err_unexp_o !== 1 || outstanding_o !== 1) begin
      n_fail++; $display("FAIL unexp_range: err=%b outst=%0d exp 1/1", err_unexp_o, outstanding_o); end
    send_rsp(EXT, 0, 12'h0);
    n_checks++; if (err_unexp_o !== 0 || done_valid_o !== 0) begin
      n_fail++; $display("FAIL ext_cmp: err=%b done=%b exp 0/0", err_unexp_o, done_valid_o); end
    send_rsp(GO, 0, 12'h004);
    n_checks++; if (done_valid_o !== 1 || done_state_o !== 4 || err_unexp_o !== 0) begin
      n_fail++; $display("FAIL unexp_then_go: done=%b st=%h err=%b exp 1/4/0", done_valid_o, done_state_o, err_unexp_o); end
  endtask

  task automatic test_async_reset();
    send_req(ITOMWR, 46'h1, 0);
    send_req(RD_OWN, 46'h2, 0);
    #1 rst_n = 0; #1;
    n_checks++; if (outstanding_o !== 0 || d2h_req_valid_o !== 0) begin
      n_fail++; $display("FAIL areset: outst=%0d d2h_v=%b exp 0/0", outstanding_o, d2h_req_valid_o); end
    tick(); rst_n = 1; tick();
    send_req(RD_OWN, 46'h3, 0);
    n_checks++; if (d2h_req_cqid_o !== 0 || outstanding_o !== 1) begin
      n_fail++; $display("FAIL areset_realloc: cqid=%h outst=%0d exp 0/1", d2h_req_cqid_o, outstanding_o); end
    send_rsp(GO, 0, 12'h0);
  endtask

  task automatic test_random();
    logic [3:0] rop_tbl [8] = '{WP, GO, GO_WP, EXT, GO_WP_DROP, FGO, FGO_WP, GO_ERR};
    bit m_dv = 0, m_dnt = 0;
    int m_dcq = 0;
    logic [4:0]  m_dop = 0;
    logic [45:0] m_dadr = 0;
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_wr[i] = 0; m_go[i] = 0; m_pull[i] = 0; m_gst[i] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit exp_ready, accept, e_err, e_done, e_pull, e_derr;
      logic [3:0] e_dst;
      int aidx, rcq;
      req_valid_i     = ($urandom % 3) == 0;
      req_opcode_i    = 5'($urandom);
      req_addr_i      = 46'({$urandom, $urandom});
      req_nt_i        = 1'($urandom);
      d2h_req_ready_i = ($urandom % 4) != 0;
      h2d_rsp_valid_i = 1'($urandom);
      rcq             = $urandom_range(0, N + 1);
      h2d_rsp_cqid_i  = 12'(rcq);
      h2d_rsp_opcode_i = (($urandom % 10) == 0) ? 4'($urandom) : rop_tbl[$urandom_range(0, 7)];
      h2d_rsp_data_i  = 12'($urandom);
      #1;
      aidx = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) aidx = i;
      exp_ready = (aidx >= 0) && (!m_dv || d2h_req_ready_i);
      accept = req_valid_i && exp_ready;
      n_checks++; if (req_ready_o !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, req_ready_o, exp_ready); end
      e_err = 0; e_done = 0; e_pull = 0; e_derr = 0; e_dst = 0;
      if (h2d_rsp_valid_i)
        model_rsp(h2d_rsp_opcode_i, rcq, h2d_rsp_data_i, e_err, e_done, e_pull, e_derr, e_dst);
      if (accept) begin
        m_busy[aidx] = 1; m_wr[aidx] = model_is_wr(req_opcode_i); m_go[aidx] = 0; m_pull[aidx] = 0;
        m_dv = 1; m_dcq = aidx; m_dop = req_opcode_i; m_dadr = req_addr_i; m_dnt = req_nt_i;
      end else if (d2h_req_ready_i) m_dv = 0;
      tick();
      n_checks++; if (d2h_req_valid_o !== m_dv || (m_dv && (d2h_req_cqid_o !== 12'(m_dcq) ||
                      d2h_req_opcode_o !== m_dop || d2h_req_addr_o !== m_dadr || d2h_req_nt_o !== m_dnt))) begin
        n_fail++; $display("FAIL rnd_d2h c%0d: v=%b cqid=%h op=%h exp v=%b cqid=%h op=%h", cyc,
                           d2h_req_valid_o, d2h_req_cqid_o, d2h_req_opcode_o, m_dv, 12'(m_dcq), m_dop); end
      n_checks++; if (done_valid_o !== e_done || (e_done && (done_cqid_o !== 12'(rcq) ||
                      done_state_o !== e_dst || done_err_o !== e_derr))) begin
        n_fail++; $display("FAIL rnd_done c%0d: v=%b cqid=%h st=%h err=%b exp v=%b cqid=%h st=%h err=%b", cyc,
                           done_valid_o, done_cqid_o, done_state_o, done_err_o, e_done, 12'(rcq), e_dst, e_derr); end
      n_checks++; if (wrpull_valid_o !== e_pull || (e_pull && (wrpull_cqid_o !== 12'(rcq) ||
                      wrpull_uqid_o !== h2d_rsp_data_i))) begin
        n_fail++; $display("FAIL rnd_wrpull c%0d: v=%b cqid=%h uqid=%h exp v=%b cqid=%h uqid=%h", cyc,
                           wrpull_valid_o, wrpull_cqid_o, wrpull_uqid_o, e_pull, 12'(rcq), h2d_rsp_data_i); end
      n_checks++; if (err_unexp_o !== e_err || outstanding_o !== 13'(model_count())) begin
        n_fail++; $display("FAIL rnd_err_outst c%0d: err=%b outst=%0d exp err=%b outst=%0d", cyc,
                           err_unexp_o, outstanding_o, e_err, model_count()); end
    end
    req_valid_i = 0; h2d_rsp_valid_i = 0; d2h_req_ready_i = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_combined();
    test_write_split();
    test_full();
    test_backpressure();
    test_unexpected();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
